l_function_decoder: RTL and testbench
=====================================

# l_function_decoder

- Decryption-side counterpart of the candidate encryptor.
- Consumes one ciphertext-power stream u = c^λ mod n² (block-serial, LSB block first, as produced by the exponentiator/Montgomery chain).
- Emits the Paillier L-function result q = (u−1)/n as a block-serial stream of BITS_IN_NUM/REGISTER_SIZE blocks.
- Division is exact, so it is computed as q = (u−1)·n⁻¹ mod 2^BITS_IN_NUM (LSB-first Jebelean exact division) against a block-streamed n, using the same consumed-pointer convention as the encrypt side.

## Interface

Parameters:
- REGISTER_SIZE, default 32: block width W.
- BITS_IN_NUM, default 4096: bit width of n.
- Derived localparams:
  - N = BITS_IN_NUM/REGISTER_SIZE: output blocks, and n blocks.
  - NUM_BLOCKS_IN = 2·N: input blocks.

Ports:
- clk_in, in, 1: clock; single clock domain.
- rst_in, in, 1: reset; synchronous, active-high.
- valid_in, in, 1: data_in carries a block of u.
- data_in, in, W: u block, LSB block first.
- ready_out, out, 1: block is accepting u blocks.
- n_in, in, W: current block of n, driven by top level from its pointer.
- consumed_n_out, out, 1: one-cycle pulse; top advances its n pointer, wrapping N−1→0.
- n_inv_in, in, W: n⁻¹ mod 2^W, with n odd; held static for the whole operation.
- valid_out, out, 1: one-cycle pulse per quotient block.
- data_out, out, W: quotient block q_i, LSB block first.
- final_out, out, 1: high together with valid_out on q_{N−1}.
- error_out, out, 1: sticky; see Configuration.

## Operation

- Local storage: X[0..N−1], N words of W bits, inferred as a simple dual-port RAM with 1-cycle registered read.
- Only the low N words of u−1 are stored. Upper words cannot affect q mod 2^(W·N); the upper N input blocks are accepted and dropped.

State machine: IDLE → LOAD → QDIG → MAC → DRAIN → QDIG … → IDLE.
- IDLE:
  - ready_out=1.
  - Borrow register b←1, used to implement the −1.
  - The first valid_in block moves the FSM to LOAD and is stored.
- LOAD:
  - For each accepted block k, store data_in − b into X[k] when k<N, with b ← (data_in==0)&&b.
  - Blocks with k≥N are discarded.
  - After block 2N−1 is accepted: ready_out=0, i←0, go to QDIG.
- QDIG (step i):
  - Read X[i].
  - Next cycle: q ← (X[i]·n_inv_in) mod 2^W, registered.
  - valid_out=1 and data_out=q for one cycle; final_out=1 if i==N−1.
  - If i==N−1, go to IDLE; otherwise go to MAC with j←0 and carry c←0.
- MAC:
  - For j=0..N−1, one n block per cycle: consumed_n_out pulses every cycle, N pulses per step.
  - For j ≤ N−1−i: X[i+j] ← X[i+j] − lo(q·n_j + c), with c ← hi(q·n_j + c) + borrow.
  - 2-cycle read-modify-write pipeline, full 2W-bit product.
  - For j > N−1−i: n block consumed, no write. This keeps the top-level pointer wrapped back to n_0.
- DRAIN:
  - 2 cycles so the final write lands before X[i+1] is read.
  - Then i←i+1, go to QDIG.
- valid_in while ready_out=0 is ignored; no data corruption.
- There is no output backpressure; the consumer must accept every valid_out pulse.

## Timing

- Reset values: ready_out=1, valid_out=0, final_out=0, data_out=0, consumed_n_out=0, error_out=0. FSM returns to IDLE; borrow, i and j are cleared.
- Reset mid-LOAD or mid-MAC aborts cleanly. The top level must also reset its n pointer, so block 0 is presented after reset.
- q_0 valid_out: 2 cycles after the cycle the last input block is accepted.
- Consecutive valid_out pulses: exactly N+4 cycles apart (2 QDIG + N MAC + 2 DRAIN).
- consumed_n_out: exactly N pulses between consecutive valid_out pulses; none in IDLE, LOAD or QDIG.
- A new operation may start in the cycle after final_out: ready_out rises that cycle.
- Input may be bursty; LOAD simply waits on valid_in.

## Configuration

- L_FUNCTION_INV_CHECK_EN defined:
  - In the first QDIG, the block checks (n_0·n_inv_in) mod 2^W == 1.
  - On mismatch, error_out is set and held until rst_in. The computation still completes.
- Not defined: no check logic; error_out is tied 0.

## Test plan

Unless stated otherwise, W=8, BITS_IN_NUM=16 (N=2).

- Basic decode: n=0x000B, n_inv_in=0xA3, u=0x00000038 (blocks 38,00,00,00) → data_out 0x05 then 0x00. final_out on the second block; pulses 6 cycles apart.
- Borrow chain: n=0x0101, n_inv_in=0x01, u=0x00010000 (blocks 00,00,01,00) → 0xFF then 0x00.
- Pointer discipline: any decode → exactly 2 consumed_n_out pulses between the two valid_out pulses, 0 elsewhere.
- Ignored input and back-to-back: valid_in toggling during compute changes nothing. A second decode starting the cycle after final_out yields a correct result.
- Reset mid-MAC: assert rst_in one cycle during step 0 → all outputs return to reset values. A following decode of the basic case gives 0x05, 0x00.
- Inverse check, with L_FUNCTION_INV_CHECK_EN: n=0x000B, n_inv_in=0x00 → error_out=1 from the first QDIG cycle until reset. Without the macro, error_out stays 0.

Source files
------------

// File: rtl/l_function_decoder_if.sv
// Stream bundle for the L-function decoder: u input, n block feed, quotient output.
interface l_function_decoder_if #(
  parameter int REGISTER_SIZE = 32
);
  logic                     valid_in;
  logic [REGISTER_SIZE-1:0] data_in;
  logic                     ready_out;
  logic [REGISTER_SIZE-1:0] n_in;
  logic                     consumed_n_out;
  logic [REGISTER_SIZE-1:0] n_inv_in;
  logic                     valid_out;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     final_out;
  logic                     error_out;

  modport master (
    output valid_in, data_in, n_in, n_inv_in,
    input  ready_out, consumed_n_out, valid_out, data_out, final_out, error_out
  );

  modport slave (
    input  valid_in, data_in, n_in, n_inv_in,
    output ready_out, consumed_n_out, valid_out, data_out, final_out, error_out
  );
endinterface

// File: rtl/l_function_decoder.sv
// Paillier L-function q = (u-1)/n by LSB-first exact division against a block-streamed n.
// Optional n_inv self-check enabled by defining L_FUNCTION_INV_CHECK_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for first u block, borrow implicitly 1
// S_LOAD  | store u-1 low words, drop upper words
// S_QDIG  | 2 cycles: read X[i] lands, q_i registered and emitted
// S_MAC   | N cycles: X[i+j] -= q_i*n_j with carry, one n block per cycle
// S_DRAIN | 2 cycles: last write lands before X[i+1] is read
module l_function_decoder #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  l_function_decoder_if.slave  bus
);
  localparam int W  = REGISTER_SIZE;
  localparam int N  = BITS_IN_NUM / REGISTER_SIZE;
  localparam int NUM_BLOCKS_IN = 2 * N;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(NUM_BLOCKS_IN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QDIG, S_MAC, S_DRAIN} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_i;
  logic [AW-1:0]   r_j;
  logic [KW-1:0]   r_k;
  logic            r_b;
  logic            r_tmr;
  logic [W-1:0]    r_q;
  logic            r_ready;
  logic            r_valid;
  logic            r_final;
  logic            r_cons;
  logic [2*W-1:0]  r_p;
  logic            r_pv;
  logic [AW-1:0]   r_pa;
  logic [W:0]      r_c;
  logic [W-1:0]    r_mem [0:N-1];
  logic [W-1:0]    r_rd;

  logic            w_accept;
  logic            w_b_in;
  logic            w_last_in;
  logic            w_load_we;
  logic [AW:0]     w_ij;
  logic            w_mac_wr;
  logic [2*W:0]    w_s;
  logic [W:0]      w_diff;
  logic            w_bor;
  logic            w_we;
  logic [AW-1:0]   w_wa;
  logic [W-1:0]    w_wd;
  logic [AW-1:0]   w_ra;
  logic [W-1:0]    w_q;

  assign w_accept  = bus.valid_in && r_ready;
  assign w_b_in    = (r_state == S_IDLE) ? 1'b1 : r_b;
  assign w_last_in = w_accept && (r_k == KW'(NUM_BLOCKS_IN - 1));
  assign w_load_we = w_accept && (r_k < KW'(N));
  assign w_ij      = {1'b0, r_i} + {1'b0, r_j};
  assign w_mac_wr  = (w_ij < (AW+1)'(N));
  assign w_q       = r_rd * bus.n_inv_in;

  // Second pipeline stage of the MAC: subtract lo(q*n_j + c) from the word read last cycle.
  assign w_s    = {1'b0, r_p} + {{W{1'b0}}, r_c};
  assign w_diff = {1'b0, r_rd} - {1'b0, w_s[W-1:0]};
  assign w_bor  = w_diff[W];

  assign w_we = w_load_we || r_pv;
  assign w_wa = r_pv ? r_pa : r_k[AW-1:0];
  assign w_wd = r_pv ? w_diff[W-1:0] : (bus.data_in - {{(W-1){1'b0}}, w_b_in});

  always_comb begin
    w_ra = '0;
    case (r_state)
      S_MAC:   w_ra = w_mac_wr ? w_ij[AW-1:0] : '0;
      S_DRAIN: w_ra = r_i + AW'(1);
      default: w_ra = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rd <= r_mem[w_ra];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_b     <= 1'b0;
      r_tmr   <= 1'b0;
      r_q     <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_final <= 1'b0;
      r_cons  <= 1'b0;
      r_p     <= '0;
      r_pv    <= 1'b0;
      r_pa    <= '0;
      r_c     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_final <= 1'b0;
      r_cons  <= 1'b0;
      r_pv    <= 1'b0;
      if (r_pv) r_c <= w_s[2*W:W] + {{W{1'b0}}, w_bor};
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_b <= (bus.data_in == '0) && w_b_in;
            if (w_last_in) begin
              r_k     <= '0;
              r_ready <= 1'b0;
              r_i     <= '0;
              r_tmr   <= 1'b1;
              r_state <= S_QDIG;
            end else begin
              r_k     <= r_k + KW'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_QDIG: begin
          if (r_tmr) begin
            r_q     <= w_q;
            r_valid <= 1'b1;
            r_final <= (r_i == AW'(N - 1));
            r_tmr   <= 1'b0;
          end else if (r_i == AW'(N - 1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_MAC;
            r_j     <= '0;
            r_c     <= '0;
            r_cons  <= 1'b1;
          end
        end
        S_MAC: begin
          // Every n block is consumed so the external pointer wraps back to n_0.
          r_p  <= (2*W)'(r_q) * (2*W)'(bus.n_in);
          r_pv <= w_mac_wr;
          r_pa <= w_ij[AW-1:0];
          if (r_j == AW'(N - 1)) begin
            r_state <= S_DRAIN;
            r_tmr   <= 1'b1;
          end else begin
            r_j    <= r_j + AW'(1);
            r_cons <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_tmr) begin
            r_tmr <= 1'b0;
          end else begin
            r_i     <= r_i + AW'(1);
            r_tmr   <= 1'b1;
            r_state <= S_QDIG;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L_FUNCTION_INV_CHECK_EN
  logic         r_err;
  logic [W-1:0] w_chk;
  assign w_chk = bus.n_in * bus.n_inv_in;

  // n_in still presents n_0 when the last block is taken, so the flag shows from the first QDIG cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_LOAD) && w_last_in && (w_chk != W'(1))) begin
      r_err <= 1'b1;
    end
  end
  assign bus.error_out = r_err;
`else
  assign bus.error_out = 1'b0;
`endif

  assign bus.ready_out      = r_ready;
  assign bus.valid_out      = r_valid;
  assign bus.data_out       = r_q;
  assign bus.final_out      = r_final;
  assign bus.consumed_n_out = r_cons;
endmodule

// File: tb/tb_l_function_decoder.sv
// Bench for l_function_decoder at W=8, BITS_IN_NUM=16 against a modular-arithmetic model.
module tb_l_function_decoder;
  localparam int W    = 8;
  localparam int BITS = 16;
  localparam int N    = 2;
  localparam int NB   = 4;
`ifdef L_FUNCTION_INV_CHECK_EN
  localparam bit EXP_ERR_BAD_INV = 1'b1;
`else
  localparam bit EXP_ERR_BAD_INV = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  l_function_decoder_if #(.REGISTER_SIZE(W)) bus();
  l_function_decoder #(.REGISTER_SIZE(W), .BITS_IN_NUM(BITS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk_in) cyc++;

  logic [15:0] n_val    = 16'h000B;
  logic [7:0]  ninv_val = 8'hA3;
  int          nptr     = 0;

  // Top-level n pointer: advances on each consumed pulse, wraps N-1 -> 0.
  always @(posedge clk_in) begin
    if (rst_in) nptr <= 0;
    else if (bus.consumed_n_out) nptr <= (nptr == N - 1) ? 0 : nptr + 1;
  end
  assign bus.n_in     = n_val[nptr*8 +: 8];
  assign bus.n_inv_in = ninv_val;

  typedef struct {
    logic [7:0] d;
    bit         fin;
    bit         chk;
    int         idx;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] model_q(input logic [31:0] u, input logic [15:0] n);
    logic [15:0] um1;
    logic [15:0] inv;
    logic [31:0] pr;
    logic [31:0] xv;
    um1 = u[15:0] - 16'd1;
    inv = '0;
    for (int x = 1; x < 65536; x += 2) begin
      xv = x;
      pr = n * xv[15:0];
      if (pr[15:0] == 16'd1) inv = xv[15:0];
    end
    pr = um1 * inv;
    return pr[15:0];
  endfunction

  function automatic logic [7:0] inv8(input logic [7:0] n);
    logic [15:0] pr;
    logic [7:0]  r;
    logic [15:0] xv;
    r = '0;
    for (int x = 1; x < 256; x += 2) begin
      xv = x;
      pr = n * xv[7:0];
      if (pr[7:0] == 8'd1) r = xv[7:0];
    end
    return r;
  endfunction

  // Compare process: timing, pointer discipline, data and flags every cycle.
  int   acc_k    = 0;
  int   acc_cyc  = 0;
  int   last_v   = 0;
  int   cons     = 0;
  bit   busy     = 1'b0;
  bit   exp_err  = 1'b0;
  exp_t e;

  always @(negedge clk_in) begin
    if (rst_in) begin
      expq.delete();
      acc_k   = 0;
      busy    = 1'b0;
      cons    = 0;
      exp_err = 1'b0;
    end else begin
      check("ready_out", bus.ready_out, !busy);
      check("error_out", bus.error_out, exp_err);
      check("final_without_valid", bus.final_out & ~bus.valid_out, 0);
      if (bus.consumed_n_out) cons++;
      if (bus.valid_out) begin
        if (expq.size() == 0) begin
          check("unexpected_valid", bus.valid_out, 0);
        end else begin
          e = expq.pop_front();
          if (e.chk) check("data_out", bus.data_out, e.d);
          check("final_out", bus.final_out, e.fin);
          if (e.idx == 0) begin
            check("q0_latency", cyc - acc_cyc, 2);
            check("consumed_before_q0", cons, 0);
          end else begin
            check("valid_spacing", cyc - last_v, N + 4);
            check("consumed_between", cons, N);
          end
        end
        got.push_back(bus.data_out);
        cons   = 0;
        last_v = cyc;
      end
      if (bus.valid_in && bus.ready_out) begin
        acc_k++;
        if (acc_k == NB) begin
          acc_k   = 0;
          acc_cyc = cyc;
          busy    = 1'b1;
          if (EXP_ERR_BAD_INV && (((int'(n_val[7:0]) * int'(ninv_val)) & 255) != 1)) exp_err = 1'b1;
        end
      end
      if (bus.final_out) busy = 1'b0;
    end
  end

  task automatic send_u(input logic [31:0] u, input bit no_gap);
    int gaps;
    for (int k = 0; k < NB; k++) begin
      gaps = no_gap ? 0 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        @(posedge clk_in); #1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'($urandom);
      end
      @(posedge clk_in); #1;
      bus.valid_in = 1'b1;
      bus.data_in  = u[8*k +: 8];
    end
  endtask

  task automatic wait_final(input bit toggle);
    bit seen;
    seen = 1'b0;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (bus.final_out) begin
        seen = 1'b1;
      end else begin
        bus.valid_in = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.data_in  = 8'($urandom);
        @(posedge clk_in); #1;
      end
    end
    bus.valid_in = 1'b0;
    check("final_seen", seen, 1);
    @(negedge clk_in); #1;
  endtask

  task automatic push_exp(input logic [15:0] q, input bit chk);
    expq.push_back('{d: q[7:0],  fin: 1'b0, chk: chk, idx: 0});
    expq.push_back('{d: q[15:8], fin: 1'b1, chk: chk, idx: 1});
  endtask

  task automatic decode(input logic [15:0] n, input logic [7:0] ninv, input logic [31:0] u,
                        input bit chk, input bit no_gap, input bit toggle);
    n_val    = n;
    ninv_val = ninv;
    push_exp(model_q(u, n), chk);
    send_u(u, no_gap);
    wait_final(toggle);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, bus.ready_out, 1);
    check({tag, "_valid"}, bus.valid_out, 0);
    check({tag, "_final"}, bus.final_out, 0);
    check({tag, "_data"},  bus.data_out, 0);
    check({tag, "_cons"},  bus.consumed_n_out, 0);
    check({tag, "_err"},   bus.error_out, 0);
  endtask

  task automatic check_got(input string tag, input logic [7:0] q0, input logic [7:0] q1);
    check({tag, "_count"}, got.size(), 2);
    check({tag, "_q0"}, (got.size() > 0) ? got[0] : 8'hxx, q0);
    check({tag, "_q1"}, (got.size() > 1) ? got[1] : 8'hxx, q1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic [15:0] rn;
  logic [31:0] ru;
  logic [15:0] rq;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    rst_in       = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    check_reset_vals("reset");

    got.delete();
    decode(16'h000B, 8'hA3, 32'h0000_0038, 1'b1, 1'b0, 1'b0);
    check_got("basic", 8'h05, 8'h00);

    got.delete();
    decode(16'h0101, 8'h01, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
    check_got("borrow", 8'hFF, 8'h00);

    for (int r = 0; r < 10; r++) begin
      rn = 16'($urandom) | 16'h0001;
      if (r % 2 == 1) begin
        rq = 16'($urandom);
        ru = {16'($urandom), 16'(rq * rn + 16'd1)};
      end else begin
        ru = $urandom;
      end
      decode(rn, inv8(rn[7:0]), ru, 1'b1, r < 4, (r % 3) == 0);
    end

    got.delete();
    n_val    = 16'h000B;
    ninv_val = 8'hA3;
    push_exp(model_q(32'h0000_0038, 16'h000B), 1'b1);
    send_u(32'h0000_0038, 1'b0);
    @(posedge clk_in); #1 bus.valid_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("mid_mac_pulse", bus.consumed_n_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    check_reset_vals("mac_reset");
    got.delete();
    decode(16'h000B, 8'hA3, 32'h0000_0038, 1'b1, 1'b0, 1'b1);
    check_got("after_reset", 8'h05, 8'h00);

    decode(16'h000B, 8'h00, 32'h1234_5638, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_in);
    #1 check("err_held", bus.error_out, EXP_ERR_BAD_INV);
    rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    check("err_cleared", bus.error_out, 0);

    repeat (4) @(posedge clk_in);
    #1 check("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
